// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: MDU state encoding and
// the R-type funct codes that drive the multiply/divide unit.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DZ   = 2'd3
    } mdu_state_t;

    localparam logic [5:0] FUNCT_MULT = 6'h18;
    localparam logic [5:0] FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] FUNCT_MFHI = 6'h10;
    localparam logic [5:0] FUNCT_MFLO = 6'h12;

    // True for the two funct codes that start a multi-cycle MDU operation.
    function automatic logic is_mdu_start_funct(input logic [5:0] funct);
        return (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: shift-add multiply or restoring divide
// on unsigned magnitudes held in a {hi,lo} register pair.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             op_div,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] sub_tmp;
    logic [WIDTH:0] sub_diff;

    // Multiply: lo holds the multiplier, hi the partial product; the carry bit
    // of the add shifts into hi. Divide: hi is the partial remainder, lo shifts
    // the dividend out and the quotient bits in; bit WIDTH of the difference is
    // the borrow.
    always_comb begin
        add_sum  = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);
        sub_tmp  = {hi_in, lo_in[WIDTH-1]};
        sub_diff = sub_tmp - {1'b0, operand};
        hi_out   = hi_in;
        lo_out   = lo_in;
        if (op_div) begin
            if (!sub_diff[WIDTH]) begin
                hi_out = sub_diff[WIDTH-1:0];
                lo_out = {lo_in[WIDTH-2:0], 1'b1};
            end else begin
                hi_out = sub_tmp[WIDTH-1:0];
                lo_out = {lo_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_out = add_sum[WIDTH:1];
            lo_out = {add_sum[0], lo_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed MULT/DIV engine with HI/LO registers, one bit per cycle,
// sign fix-up in a final cycle; feeds mfhi/mflo of the write-data mux.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mdu_state_t       state;
    logic [CW-1:0]    counter;
    logic             op_div;
    logic             neg_result;
    logic             neg_rem;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [2*WIDTH-1:0] product_fixed;
    logic [WIDTH-1:0] quot_fixed;
    logic [WIDTH-1:0] rem_fixed;
    logic             accept;

    // Magnitudes stay unsigned in WIDTH bits so the most negative value maps to 2^(WIDTH-1).
    assign abs_a  = a[WIDTH-1] ? -a : a;
    assign abs_b  = b[WIDTH-1] ? -b : b;
    assign accept = (state == IDLE) && (start_mult || start_div);
    assign busy   = (state != IDLE);

    assign product_fixed = neg_result ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quot_fixed    = neg_result ? -acc_lo : acc_lo;
    assign rem_fixed     = neg_rem ? -acc_hi : acc_hi;

    mdu_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .op_div (op_div),
        .hi_in  (acc_hi),
        .lo_in  (acc_lo),
        .operand(operand_b),
        .hi_out (step_hi),
        .lo_out (step_lo)
    );

    // Sequencer: accept in IDLE (MULT wins a tie), iterate WIDTH times in RUN,
    // apply signs and commit HI/LO in FIX; a zero divisor short-cuts through DZ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            counter    <= '0;
            op_div     <= 1'b0;
            neg_result <= 1'b0;
            neg_rem    <= 1'b0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            operand_b  <= '0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_div     <= !start_mult;
                        neg_result <= a[WIDTH-1] ^ b[WIDTH-1];
                        neg_rem    <= a[WIDTH-1];
                        acc_hi     <= '0;
                        acc_lo     <= abs_a;
                        operand_b  <= abs_b;
                        div_zero   <= 1'b0;
                        counter    <= CW'(WIDTH - 1);
                        state      <= (!start_mult && (b == '0)) ? DZ : RUN;
                    end
                end
                RUN: begin
                    acc_hi  <= step_hi;
                    acc_lo  <= step_lo;
                    counter <= counter - CW'(1);
                    if (counter == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (op_div) begin
                        hi <= rem_fixed;
                        lo <= quot_fixed;
                    end else begin
                        hi <= product_fixed[2*WIDTH-1:WIDTH];
                        lo <= product_fixed[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                DZ: begin
                    div_zero <= 1'b1;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed corner cases plus random
// MULT/DIV traffic checked against a plain signed-arithmetic model.
module tb_mult_div_unit;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
        int           issue_cyc;
        string        tag;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start_mult = 1'b0;
    logic         start_div = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    exp_t         sb_q[$];
    int           cycle_count = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_mult(start_mult),
        .start_div (start_div),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_count <= cycle_count + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
                check({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
                check({e.tag, "_div_zero"}, 64'(div_zero), 64'(e.dz));
                check({e.tag, "_latency"}, 64'(cycle_count - e.issue_cyc), 64'(e.lat));
            end
        end
    end

    // Reference model: signed 64-bit arithmetic, truncating division.
    function automatic exp_t model(input bit is_mult, input logic [W-1:0] av,
                                   input logic [W-1:0] bv, input string tag);
        exp_t   e;
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        sa = $signed(av);
        sb = $signed(bv);
        e.tag = tag;
        e.issue_cyc = 0;
        if (is_mult) begin
            p     = sa * sb;
            e.hi  = p[63:32];
            e.lo  = p[31:0];
            e.dz  = 1'b0;
            e.lat = W + 2;
        end else if (bv == '0) begin
            e.hi  = model_hi;
            e.lo  = model_lo;
            e.dz  = 1'b1;
            e.lat = 2;
        end else begin
            q     = sa / sb;
            r     = sa % sb;
            e.hi  = r[31:0];
            e.lo  = q[31:0];
            e.dz  = 1'b0;
            e.lat = W + 2;
        end
        return e;
    endfunction

    // Issues one operation, optionally injects a start_div while busy, and
    // returns in the done cycle so the next start lands on it.
    task automatic applyStimulus(input bit do_mult, input bit do_div, input logic [W-1:0] av,
                                 input logic [W-1:0] bv, input int inject_at, input string tag);
        exp_t e;
        bit   got;
        e = model(do_mult, av, bv, tag);
        e.issue_cyc = cycle_count;
        model_hi = e.hi;
        model_lo = e.lo;
        sb_q.push_back(e);
        start_mult = do_mult;
        start_div  = do_div;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        check({tag, "_busy_run"}, 64'(busy), 64'd1);
        got = 1'b0;
        for (int i = 1; i < 60; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (i == inject_at) begin
                start_div = 1'b1;
                a = 32'h1234_5678;
                b = 32'h0;
            end
            @(posedge clk);
            #1;
            start_div = 1'b0;
        end
        if (!got) check({tag, "_done_timeout"}, 64'd0, 64'd1);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_div_zero"}, 64'(div_zero), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h8000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'($urandom_range(0, 20));
            3: v = -32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset", '0, '0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("after_reset", '0, '0);

        applyStimulus(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, -1, "mult_7_m3");
        applyStimulus(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, -1, "mult_min_min");
        applyStimulus(1'b0, 1'b1, -32'd7, 32'd2, -1, "div_m7_2");
        applyStimulus(1'b0, 1'b1, 32'd5, 32'd0, -1, "div_by_zero");
        applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_min_m1");
        applyStimulus(1'b1, 1'b0, 32'd3, 32'd5, -1, "mult_clear_dz");
        applyStimulus(1'b1, 1'b0, 32'h0001_2345, 32'hFFF0_0007, 5, "mult_ignore_div");
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF0, 32'd9, -1, "both_start");

        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] av;
            logic [W-1:0] bv;
            bit           m;
            av = pick_operand();
            bv = ($urandom_range(0, 9) == 0) ? 32'h0 : pick_operand();
            m  = 1'($urandom_range(0, 1));
            applyStimulus(m, !m, av, bv, -1, m ? "rand_mult" : "rand_div");
        end

        // Abort a multiply at cycle 10: outputs clear immediately, no done follows.
        applyStimulus(1'b1, 1'b0, 32'd6, 32'd7, -1, "pre_abort");
        start_mult = 1'b1;
        a = 32'h0000_1234;
        b = 32'h0000_5678;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("abort", '0, '0);
        model_hi = '0;
        model_lo = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("post_abort", '0, '0);
        applyStimulus(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, -1, "div_after_abort");

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
